// File: rtl/uart_rx_buffer.sv
// Receive-side FWFT buffer: synchronizes the receiver's data_valid level, captures
// one entry per frame on its rising edge, and serves entries over valid/ready.
module uart_rx_buffer #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_WIDTH-1:0]      rx_data,
  input  logic                       rx_perr,
  input  logic                       rx_valid,
  output logic [DATA_WIDTH-1:0]      m_data,
  output logic                       m_perr,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overrun,
  input  logic                       clr_overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [CW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]          rd_ptr_q, rd_ptr_d;
  logic                   overrun_q, overrun_d;
  logic [DATA_WIDTH:0]    mem_q [DEPTH];

  logic sync_out;
  logic wr;
  logic rd;
  logic wr_accept;
  logic wr_drop;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign wr       = sync_out & ~prev_q;
  assign rd       = m_valid & m_ready;

  // A full FIFO still accepts a write when the same cycle frees the head slot.
  assign wr_accept = wr & (~full | rd);
  assign wr_drop   = wr & full & ~rd;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign m_valid = ~empty;
  assign overrun = overrun_q;
  assign {m_perr, m_data} = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], rx_valid};
    prev_d    = sync_out;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    overrun_d = overrun_q;
    if (wr_accept) wr_ptr_d = wr_ptr_q + CW'(1);
    if (rd)        rd_ptr_d = rd_ptr_q + CW'(1);
    if (wr_drop)          overrun_d = 1'b1;
    else if (clr_overrun) overrun_d = 1'b0;
  end

  // Synchronizer and edge register reset high so a level already present at
  // reset release never produces a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '1;
      prev_q    <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[wr_ptr_q[AW-1:0]] <= {rx_perr, rx_data};
  end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed bench for uart_rx_buffer: reset, latency, ordering, overrun, full with
// simultaneous read, and asynchronous reset mid-stream.
module tb_uart_rx_buffer;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int SS    = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] rx_data;
  logic          rx_perr;
  logic          rx_valid;
  logic [DW-1:0] m_data;
  logic          m_perr;
  logic          m_valid;
  logic          m_ready;
  logic [$clog2(DEPTH):0] count;
  logic          full;
  logic          empty;
  logic          overrun;
  logic          clr_overrun;

  int checks = 0;
  int passes = 0;

  uart_rx_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_perr(rx_perr),
    .rx_valid(rx_valid), .m_data(m_data), .m_perr(m_perr), .m_valid(m_valid),
    .m_ready(m_ready), .count(count), .full(full), .empty(empty),
    .overrun(overrun), .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic p);
    rx_data  = d;
    rx_perr  = p;
    rx_valid = 1'b1;
    repeat (4) step();
    rx_valid = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    rst_n = 1'b0; rx_data = '0; rx_perr = 1'b0; rx_valid = 1'b1;
    m_ready = 1'b0; clr_overrun = 1'b0;

    // Reset with rx_valid already high: no write on release
    repeat (3) step();
    rst_n = 1'b1;
    repeat (10) step();
    check("rst_count", 32'(count), 0);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_overrun", 32'(overrun), 0);
    rx_valid = 1'b0;
    repeat (4) step();
    check("rst_no_write", 32'(count), 0);

    // Single frame: m_valid rises SS+1 cycles after rx_valid, one entry only
    rx_data = 8'hA5; rx_perr = 1'b0; rx_valid = 1'b1;
    step(); check("lat_c1", 32'(m_valid), 0);
    step(); check("lat_c2", 32'(m_valid), 0);
    step(); check("lat_c3", 32'(m_valid), 1);
    repeat (37) step();
    rx_valid = 1'b0;
    repeat (4) step();
    check("single_count", 32'(count), 1);
    check("single_data", 32'(m_data), 32'hA5);
    check("single_perr", 32'(m_perr), 0);
    m_ready = 1'b1; step(); m_ready = 1'b0;
    check("single_drained", 32'(empty), 1);

    // Ordering and parity flag
    send_frame(8'h01, 1'b0);
    send_frame(8'h02, 1'b1);
    send_frame(8'h03, 1'b0);
    check("ord_count", 32'(count), 3);
    check("ord_d0", 32'(m_data), 32'h01); check("ord_p0", 32'(m_perr), 0);
    m_ready = 1'b1;
    step();
    check("ord_d1", 32'(m_data), 32'h02); check("ord_p1", 32'(m_perr), 1);
    step();
    check("ord_d2", 32'(m_data), 32'h03); check("ord_p2", 32'(m_perr), 0);
    step();
    check("ord_empty", 32'(empty), 1);
    step();
    check("ready_while_empty", 32'(count), 0);
    m_ready = 1'b0;

    // Overrun: DEPTH+1 frames, the last one dropped
    for (int i = 0; i < DEPTH; i++) send_frame(DW'(i), i[0]);
    check("ovr_full_before", 32'(full), 1);
    check("ovr_not_yet", 32'(overrun), 0);
    send_frame(8'hEE, 1'b1);
    check("ovr_full", 32'(full), 1);
    check("ovr_count", 32'(count), DEPTH);
    check("ovr_flag", 32'(overrun), 1);
    // Another drop coinciding with clr_overrun: set wins
    rx_data = 8'hEF; rx_perr = 1'b0; rx_valid = 1'b1;
    step(); step();
    clr_overrun = 1'b1; step(); clr_overrun = 1'b0;
    check("ovr_set_wins", 32'(overrun), 1);
    repeat (2) step();
    rx_valid = 1'b0;
    repeat (4) step();
    m_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check("ovr_drain_d", 32'(m_data), i);
      check("ovr_drain_p", 32'(m_perr), i % 2);
      step();
    end
    m_ready = 1'b0;
    check("ovr_drained", 32'(empty), 1);
    check("ovr_sticky", 32'(overrun), 1);
    clr_overrun = 1'b1; step(); clr_overrun = 1'b0;
    check("ovr_cleared", 32'(overrun), 0);

    // Full FIFO with a read coinciding with the write edge
    for (int i = 0; i < DEPTH; i++) send_frame(DW'(8'h10 + i), 1'b0);
    check("fr_full", 32'(full), 1);
    check("fr_head", 32'(m_data), 32'h10);
    rx_data = 8'h77; rx_perr = 1'b0; rx_valid = 1'b1;
    step(); step();
    m_ready = 1'b1; step(); m_ready = 1'b0;
    check("fr_count", 32'(count), DEPTH);
    check("fr_no_overrun", 32'(overrun), 0);
    check("fr_new_head", 32'(m_data), 32'h11);
    repeat (2) step();
    rx_valid = 1'b0;
    repeat (4) step();
    check("fr_count_hold", 32'(count), DEPTH);
    m_ready = 1'b1;
    for (int i = 1; i < DEPTH; i++) begin
      check("fr_drain", 32'(m_data), 32'h10 + i);
      step();
    end
    check("fr_last", 32'(m_data), 32'h77);
    step();
    m_ready = 1'b0;
    check("fr_empty", 32'(empty), 1);

    // Reset mid-stream clears immediately
    for (int i = 0; i < 5; i++) send_frame(DW'(8'h50 + i), 1'b0);
    check("mr_count5", 32'(count), 5);
    rst_n = 1'b0;
    #1;
    check("mr_count0", 32'(count), 0);
    check("mr_m_valid", 32'(m_valid), 0);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    send_frame(8'h3C, 1'b0);
    check("mr_new_count", 32'(count), 1);
    check("mr_new_data", 32'(m_data), 32'h3C);
    m_ready = 1'b1; step(); m_ready = 1'b0;
    check("mr_final_empty", 32'(empty), 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
